// File: rtl/sensor_serializer_if.sv
// Handshake and serial-line bundle for sensor_serializer.
// The master drives the word/load request; the slave (serializer) drives the link.
interface sensor_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             ready;
   logic             serial_out;
   logic             frame;
   logic             done;

   modport master (
      output data_in, load,
      input  ready, serial_out, frame, done
   );

   modport slave (
      input  data_in, load,
      output ready, serial_out, frame, done
   );
endinterface

// File: rtl/sensor_serializer.sv
// MSB-first parallel-to-serial transmitter, one bit per DIV clocks, done pulse at frame end.
// Optional even-parity trailer bit when SENSOR_SERIALIZER_PARITY_EN is defined.
module sensor_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input logic                clk,
   input logic                rst,
   sensor_serializer_if.slave bus
);

`ifdef SENSOR_SERIALIZER_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int SR_W  = N;
   localparam int BIT_W = $clog2(N + 1);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

`ifdef SENSOR_SERIALIZER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction
`endif

   state_t            state_r, state_s;
   logic [SR_W-1:0]   sreg_r, sreg_s;
   logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
   logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
   logic              ready_r, ready_s;
   logic              serial_r, serial_s;
   logic              frame_r, frame_s;
   logic              done_r, done_s;

   // Next-state, datapath and next-output computation
   always_comb begin
      state_s   = state_r;
      sreg_s    = sreg_r;
      bit_cnt_s = bit_cnt_r;
      div_cnt_s = div_cnt_r;
      done_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.load) begin
               state_s   = SHIFT;
`ifdef SENSOR_SERIALIZER_PARITY_EN
               sreg_s    = {bus.data_in, even_parity(bus.data_in)};
`else
               sreg_s    = bus.data_in;
`endif
               bit_cnt_s = {BIT_W{1'b0}};
               div_cnt_s = {DIV_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (div_cnt_r == DIV_LAST) begin
               div_cnt_s = {DIV_W{1'b0}};
               sreg_s    = {sreg_r[SR_W-2:0], 1'b0};
               bit_cnt_s = bit_cnt_r + BIT_W'(1);
               if (bit_cnt_r == BIT_LAST) begin
                  state_s = IDLE;
                  done_s  = 1'b1;
               end else begin
                  state_s = SHIFT;
               end
            end else begin
               div_cnt_s = div_cnt_r + DIV_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // Outputs are registered, so derive them from the state being entered
      ready_s  = (state_s == IDLE);
      frame_s  = (state_s == SHIFT);
      serial_s = (state_s == SHIFT) ? sreg_s[SR_W-1] : 1'b0;
   end

   // State, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         sreg_r    <= {SR_W{1'b0}};
         bit_cnt_r <= {BIT_W{1'b0}};
         div_cnt_r <= {DIV_W{1'b0}};
         ready_r   <= 1'b1;
         serial_r  <= 1'b0;
         frame_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         sreg_r    <= sreg_s;
         bit_cnt_r <= bit_cnt_s;
         div_cnt_r <= div_cnt_s;
         ready_r   <= ready_s;
         serial_r  <= serial_s;
         frame_r   <= frame_s;
         done_r    <= done_s;
      end
   end

   assign bus.ready      = ready_r;
   assign bus.serial_out = serial_r;
   assign bus.frame      = frame_r;
   assign bus.done       = done_r;

endmodule
